// File: rtl/vec_mag_compare_seq_if.sv
// rtl/vec_mag_compare_seq_if.sv - element-pair input and comparison-result handshake bundle
interface vec_mag_compare_seq_if #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 4
);
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_a;
  logic [ELEM_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic              out_ge;
  logic              out_eq;
  logic [IDX_W-1:0]  elem_idx;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_ge, out_eq, elem_idx
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_ge, out_eq, elem_idx
  );
endinterface

// File: rtl/vec_mag_compare_seq.sv
// rtl/vec_mag_compare_seq.sv - streaming squared-magnitude comparator of two N_ELEM vectors
// Optional CMP_MAG_OUT_EN adds mag_a/mag_b outputs carrying the final squared magnitudes.
module vec_mag_compare_seq #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 4,
  parameter int ACC_W  = 2*ELEM_W + $clog2(N_ELEM) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  vec_mag_compare_seq_if.slave     bus
`ifdef CMP_MAG_OUT_EN
  ,
  output logic [ACC_W-1:0]         mag_a,
  output logic [ACC_W-1:0]         mag_b
`endif
);

  localparam int              IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int              PROD_W   = 2*ELEM_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0]  acc_a;
  logic [ACC_W-1:0]  acc_b;
  logic [IDX_W-1:0]  idx_q;
  logic              ge_q;
  logic              eq_q;
  logic              in_ready_c;
  logic              out_valid_c;

  logic [PROD_W-1:0] prod_a;
  logic [PROD_W-1:0] prod_b;
  logic [ACC_W-1:0]  sum_a;
  logic [ACC_W-1:0]  sum_b;
  logic              accept;
  logic              last;

  // Signed square is never negative, so reading it as unsigned is exact.
  assign prod_a = $signed(bus.in_a) * $signed(bus.in_a);
  assign prod_b = $signed(bus.in_b) * $signed(bus.in_b);
  assign sum_a  = acc_a + ACC_W'(prod_a);
  assign sum_b  = acc_b + ACC_W'(prod_b);

  assign accept = bus.in_valid && (state == ACCUM);
  assign last   = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && last) begin
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // The final compare folds in the current product so the result lands one cycle after the last accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a <= '0;
      acc_b <= '0;
      idx_q <= '0;
      ge_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else if (accept) begin
      if (last) begin
        ge_q  <= (sum_a >= sum_b);
        eq_q  <= (sum_a == sum_b);
        acc_a <= '0;
        acc_b <= '0;
        idx_q <= '0;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

`ifdef CMP_MAG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
    end else if (accept && last) begin
      mag_a <= sum_a;
      mag_b <= sum_b;
    end
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_ge    = ge_q;
  assign bus.out_eq    = eq_q;
  assign bus.elem_idx  = idx_q;

endmodule

// File: tb/tb_vec_mag_compare_seq.sv
// tb/tb_vec_mag_compare_seq.sv - randomized self-checking bench for vec_mag_compare_seq
module tb_vec_mag_compare_seq;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 4;
  localparam int ACC_W  = 2*ELEM_W + $clog2(N_ELEM) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_mag_compare_seq_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

`ifdef CMP_MAG_OUT_EN
  logic [ACC_W-1:0] mag_a;
  logic [ACC_W-1:0] mag_b;
`endif

  vec_mag_compare_seq #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef CMP_MAG_OUT_EN
    ,
    .mag_a (mag_a),
    .mag_b (mag_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int a, input int b, input int i, input bit gapped);
    int n;
    if (gapped) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_a     = ELEM_W'($urandom);
        bus.in_b     = ELEM_W'($urandom);
        step();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_a     = ELEM_W'(a);
    bus.in_b     = ELEM_W'(b);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) check({tag, "_in_ready_timeout"}, 0, 1);
    check({tag, "_elem_idx"}, 64'(bus.elem_idx), 64'(i));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input string tag, input int a[N_ELEM], input int b[N_ELEM], input bit gapped);
    for (int i = 0; i < N_ELEM; i++) push(tag, a[i], b[i], i, gapped);
  endtask

  // Reference: plain squared sums, then compare.
  task automatic expect_result(input string tag, input int a[N_ELEM], input int b[N_ELEM], input bit hold5);
    longint sa;
    longint sb;
    bit     ge0;
    bit     eq0;
    sa = 0;
    sb = 0;
    for (int i = 0; i < N_ELEM; i++) begin
      sa += longint'(a[i]) * longint'(a[i]);
      sb += longint'(b[i]) * longint'(b[i]);
    end
    check({tag, "_out_valid"}, 64'(bus.out_valid), 1);
    check({tag, "_out_ge"}, 64'(bus.out_ge), 64'(sa >= sb));
    check({tag, "_out_eq"}, 64'(bus.out_eq), 64'(sa == sb));
`ifdef CMP_MAG_OUT_EN
    check({tag, "_mag_a"}, 64'(mag_a), 64'(sa));
    check({tag, "_mag_b"}, 64'(mag_b), 64'(sb));
`endif
    check({tag, "_in_ready_low"}, 64'(bus.in_ready), 0);
    ge0 = (sa >= sb);
    eq0 = (sa == sb);
    if (hold5) begin
      for (int c = 0; c < 5; c++) begin
        step();
        check({tag, "_hold_valid"}, 64'(bus.out_valid), 1);
        check({tag, "_hold_ge"}, 64'(bus.out_ge), 64'(ge0));
        check({tag, "_hold_eq"}, 64'(bus.out_eq), 64'(eq0));
        check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
    end
    step();
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 0);
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 1);
  endtask

  initial begin
    int va[N_ELEM];
    int vb[N_ELEM];
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_ge", 64'(bus.out_ge), 0);
    check("rst_eq", 64'(bus.out_eq), 0);
    check("rst_idx", 64'(bus.elem_idx), 0);
`ifdef CMP_MAG_OUT_EN
    check("rst_mag_a", 64'(mag_a), 0);
`endif
    rst = 1'b0;
    step();

    va = '{3, 4, 0, 0};           vb = '{5, 0, 0, 0};
    send_vec("v345", va, vb, 1'b0);
    expect_result("v345", va, vb, 1'b0);

    va = '{1, 1, 1, 1};           vb = '{-2, 0, 0, 1};
    send_vec("v45", va, vb, 1'b0);
    expect_result("v45", va, vb, 1'b0);

    va = '{-32768, -32768, -32768, -32768};
    vb = '{32767, 32767, 32767, 32767};
    send_vec("ext", va, vb, 1'b0);
    expect_result("ext", va, vb, 1'b0);

    va = '{-32768, -32768, -32768, -32768};
    vb = '{-32768, -32768, -32768, -32768};
    send_vec("ext_eq", va, vb, 1'b0);
    expect_result("ext_eq", va, vb, 1'b0);

    va = '{9, -9, 9, -9};         vb = '{1, 2, 3, 4};
    bus.out_ready = 1'b0;
    send_vec("bp", va, vb, 1'b0);
    expect_result("bp", va, vb, 1'b1);

    va = '{0, 0, 0, 1};           vb = '{0, 0, 0, 0};
    send_vec("clean", va, vb, 1'b0);
    expect_result("clean", va, vb, 1'b0);

    push("mid", 7, 0, 0, 1'b0);
    push("mid", 7, 0, 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 1);
    check("mid_rst_idx", 64'(bus.elem_idx), 0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    va = '{2, 2, 2, 2};           vb = '{2, 2, 2, 2};
    send_vec("after_rst", va, vb, 1'b0);
    expect_result("after_rst", va, vb, 1'b0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N_ELEM; i++) begin
        va[i] = int'($urandom_range(0, 65535)) - 32768;
        vb[i] = (v % 3 == 2) ? va[N_ELEM-1-i] : int'($urandom_range(0, 65535)) - 32768;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send_vec("rnd", va, vb, 1'b1);
      expect_result("rnd", va, vb, !bus.out_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/vec_mag_compare_seq.md
Name: vec_mag_compare_seq

Overview:
- Streaming vector-magnitude comparator for the NLP datapath.
- Accepts one element pair (a[i], b[i]) per handshake and accumulates the squared magnitude of each vector over N_ELEM elements.
- After the last element it emits a registered comparison result (|a|² ≥ |b|², |a|² == |b|²) on a valid/ready output.
- Replaces the fixed 4×16-bit combinational compare; used ahead of top-k / similarity selection logic.

Parameters:
- ELEM_W, 16, element width in bits; signed two's complement.
- N_ELEM, 4, elements per vector; ≥ 1.
- ACC_W, 2*ELEM_W+$clog2(N_ELEM)+1, magnitude accumulator width; must not overflow.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  element pair valid.
- in_ready  output  1  block can accept an element pair.
- in_a  input  ELEM_W  element i of vector A (signed).
- in_b  input  ELEM_W  element i of vector B (signed).
- out_valid  output  1  comparison result valid.
- out_ready  input  1  consumer accepts result.
- out_ge  output  1  1 when |A|² ≥ |B|².
- out_eq  output  1  1 when |A|² == |B|².
- elem_idx  output  $clog2(N_ELEM) (min 1)  index of the next element expected.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc_a=acc_b=0, elem_idx=0, in_ready=1, out_valid=0, out_ge=0, out_eq=0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- Element accept: in_valid & in_ready at a rising edge.
  - acc_a += in_a*in_a and acc_b += in_b*in_b.
  - Products are signed multiply, result treated as unsigned 2*ELEM_W bits, zero-extended to ACC_W.
  - elem_idx increments on each accept.
- Vector completion: accept when elem_idx==N_ELEM-1.
  - Compare uses the final sums, including the current product, computed combinationally in the same cycle.
  - out_ge, out_eq registered; state→RESULT; elem_idx→0; acc_a, acc_b→0.
  - Latency: out_valid asserts exactly 1 cycle after the last element accept.
- RESULT: out_ge/out_eq held stable while out_valid & !out_ready (unlimited backpressure). On out_valid & out_ready, state→ACCUM.
  - out_valid deasserts the next cycle.
  - in_ready re-asserts that same next cycle, so there is one bubble between vectors.
- Data and flags:
  - in_valid while in_ready=0 is ignored; no data loss is the producer's responsibility.
  - out_ge/out_eq retain their last value after the handshake; they are only meaningful with out_valid.
- N_ELEM==1: every accept completes a vector.
- Extreme values: in_a = -2^(ELEM_W-1) squares to 2^(2*ELEM_W-2). ACC_W guarantees no wrap for N_ELEM such elements.
- Reset mid-vector: partial sums discarded, elem_idx=0, any pending result dropped.
- No synchronous clear; the vector boundary is defined only by the element count.

Optional Feature:
- CMP_MAG_OUT_EN: when defined, adds output ports mag_a and mag_b (ACC_W each).
  - They carry the final |A|² and |B|², registered alongside out_ge/out_eq and held with them.
  - Reset value is 0.
- When undefined: the ports do not exist, the registers are not built, and the comparison behaviour is identical.

Test Plan:
- Reset then N_ELEM=4: A={3,4,0,0}, B={5,0,0,0}, in_valid held high, out_ready=1 → out_valid one cycle after the 4th accept with out_ge=1, out_eq=1; in_ready low exactly one cycle.
- A={1,1,1,1}, B={-2,0,0,1} → |A|²=4, |B|²=5 → out_ge=0, out_eq=0.
- ELEM_W=16, A all -32768, B all 32767 → |A|²=4·2^30 = 2^32 (no overflow); out_ge=1, out_eq=0. With CMP_MAG_OUT_EN: mag_a=4294967296, mag_b=4294705156.
- Backpressure: out_ready=0 for 5 cycles after a result → out_valid, out_ge, out_eq stable and in_ready=0 throughout. Release → next vector {0,0,0,1} vs {0,0,0,0} gives out_ge=1, out_eq=0, with no contamination from prior sums.
- Reset mid-vector: accept 2 elements {7,7}/{0,0}, assert rst → in_ready=1, elem_idx=0, out_valid=0. Then full vector A=B={2,2,2,2} → out_eq=1.
- Gapped input: toggle in_valid randomly over 3 consecutive vectors → results match a reference model of squared sums, in order, one per vector.
